bp_mem_block_responder: RTL and testbench



---
 rtl/bp_mem_block_responder.sv | 138 +++++++++++++
 tb/tb_bp_mem_block_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bp_mem_block_responder.sv
// Block-wide test-DRAM responder: one block read or masked block write at a
// time, a fixed access latency, and a valid/yumi response handshake.
module bp_mem_block_responder #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned block_width_p = 512,
  parameter int unsigned mem_els_p     = 1024,
  parameter int unsigned latency_p     = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic                       w_i,
  input  logic [paddr_width_p-1:0]   addr_i,
  input  logic [block_width_p-1:0]   data_i,
  input  logic [block_width_p/8-1:0] write_mask_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [block_width_p-1:0]   data_o,
  input  logic                       yumi_i
);

  localparam int unsigned bytes_lp  = block_width_p / 8;
  localparam int unsigned offset_w  = $clog2(bytes_lp);
  localparam int unsigned idx_w     = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int unsigned cnt_w     = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_wait  = 2'd1,
    e_resp  = 2'd2
  } state_e;

  state_e                   state;
  state_e                   state_n;
  logic [cnt_w-1:0]         cnt;
  logic [cnt_w-1:0]         cnt_n;
  logic [idx_w-1:0]         idx_in;
  logic [idx_w-1:0]         idx_r;
  logic [idx_w-1:0]         idx_n;
  logic [block_width_p-1:0] data_n;
  logic [block_width_p-1:0] merged;
  logic                     accept;
  logic                     unused_addr;

  logic [block_width_p-1:0] mem [mem_els_p];

  // Block index; upper address bits are dropped so addresses wrap
  assign idx_in      = addr_i[offset_w +: idx_w];
  assign unused_addr = ^{addr_i[paddr_width_p-1:offset_w+idx_w], addr_i[offset_w-1:0]};

  assign accept = ready_o & v_i;

  // Post-write view of the addressed block, needed when the response is
  // loaded at the same edge the write commits (zero latency)
  always_comb begin
    merged = mem[idx_in];
    for (int unsigned k = 0; k < bytes_lp; k++) begin
      if (write_mask_i[k]) begin
        merged[k*8 +: 8] = data_i[k*8 +: 8];
      end
    end
  end

  // Next-state, wait counter, latched index and response data
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx_r;
    data_n  = data_o;
    unique case (state)
      e_ready: begin
        if (v_i) begin
          idx_n = idx_in;
          if (latency_p == 0) begin
            state_n = e_resp;
            data_n  = w_i ? merged : mem[idx_in];
          end else begin
            state_n = e_wait;
            cnt_n   = cnt_w'(1);
          end
        end
      end
      e_wait: begin
        if (cnt == cnt_w'(latency_p)) begin
          state_n = e_resp;
          cnt_n   = '0;
          data_n  = mem[idx_r];
        end else begin
          cnt_n = cnt + cnt_w'(1);
        end
      end
      e_resp: begin
        if (yumi_i) begin
          state_n = e_ready;
        end
      end
      default: begin
        state_n = e_ready;
        cnt_n   = '0;
      end
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= e_ready;
      cnt     <= '0;
      idx_r   <= '0;
      ready_o <= 1'b1;
      v_o     <= 1'b0;
      data_o  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx_r   <= idx_n;
      ready_o <= (state_n == e_ready);
      v_o     <= (state_n == e_resp);
      data_o  <= data_n;
    end
  end

  // Byte-masked write commits at the accept edge; storage ignores reset
  always_ff @(posedge clk_i) begin
    if (!reset_i && accept && w_i) begin
      for (int unsigned k = 0; k < bytes_lp; k++) begin
        if (write_mask_i[k]) begin
          mem[idx_in][k*8 +: 8] <= data_i[k*8 +: 8];
        end
      end
    end
  end

  // Handshake protocol checks
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
  a_v_known:      assert property (@(posedge clk_i) disable iff (reset_i) !$isunknown(v_i));

endmodule

// File: tb/tb_bp_mem_block_responder.sv
// Directed bench: a latency-4 responder and a latency-0 responder side by side.
module tb_bp_mem_block_responder;

  logic         clk = 1'b0;
  logic         rst4, rst0;
  logic         v4, v0, yumi4, yumi0;
  logic         w;
  logic [39:0]  addr;
  logic [511:0] wdata;
  logic [63:0]  mask;
  logic         ready4, vo4, ready0, vo0;
  logic [511:0] data4, data0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bp_mem_block_responder #(.latency_p(4)) dut (
    .clk_i(clk), .reset_i(rst4), .v_i(v4), .w_i(w), .addr_i(addr),
    .data_i(wdata), .write_mask_i(mask), .ready_o(ready4), .v_o(vo4),
    .data_o(data4), .yumi_i(yumi4)
  );

  bp_mem_block_responder #(.latency_p(0)) dut0 (
    .clk_i(clk), .reset_i(rst0), .v_i(v0), .w_i(w), .addr_i(addr),
    .data_i(wdata), .write_mask_i(mask), .ready_o(ready0), .v_o(vo0),
    .data_o(data0), .yumi_i(yumi0)
  );

  typedef struct {
    bit           sel;   // 1 = latency-0 instance
    logic         w;
    logic [39:0]  addr;
    logic [511:0] data;
    logic [63:0]  mask;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full request/response transaction with latency and handshake checks
  task automatic txn(input vec_t t, input int idx);
    int lat;
    int lat_exp;
    lat_exp = t.sel ? 0 : 4;
    @(negedge clk);
    w = t.w; addr = t.addr; wdata = t.data; mask = t.mask;
    if (t.sel) v0 = 1'b1; else v4 = 1'b1;
    check($sformatf("v%0d ready_idle", idx), t.sel ? ready0 : ready4, 512'd1);
    @(posedge clk); #1;
    v0 = 1'b0; v4 = 1'b0;
    check($sformatf("v%0d ready_busy", idx), t.sel ? ready0 : ready4, 512'd0);
    lat = 0;
    while (!(t.sel ? vo0 : vo4) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), 512'(lat), 512'(lat_exp));
    check($sformatf("v%0d data", idx), t.sel ? data0 : data4, t.exp);
    @(negedge clk);
    if (t.sel) yumi0 = 1'b1; else yumi4 = 1'b1;
    @(posedge clk); #1;
    yumi0 = 1'b0; yumi4 = 1'b0;
    check($sformatf("v%0d ready_after_yumi", idx), t.sel ? ready0 : ready4, 512'd1);
    check($sformatf("v%0d v_after_yumi", idx), t.sel ? vo0 : vo4, 512'd0);
  endtask

  logic [511:0] blk_a5, blk_part, blk_alt, blk_5a, blk_5a11, blk_77;

  initial begin
    rst4 = 1'b1; rst0 = 1'b1;
    v4 = 1'b0; v0 = 1'b0; yumi4 = 1'b0; yumi0 = 1'b0;
    w = 1'b0; addr = '0; wdata = '0; mask = '0;

    blk_a5   = {64{8'hA5}};
    blk_part = {{60{8'hA5}}, {4{8'hFF}}};
    blk_alt  = {32{8'h00, 8'h3C}};
    blk_5a   = {64{8'h5A}};
    blk_5a11 = {{63{8'h5A}}, 8'h11};
    blk_77   = {64{8'h77}};

    vecs[0] = '{0, 1'b0, 40'h40,    '0,          '0,            '0};
    vecs[1] = '{0, 1'b1, 40'h80,    blk_a5,      {64{1'b1}},    blk_a5};
    vecs[2] = '{0, 1'b0, 40'h80,    '0,          '0,            blk_a5};
    vecs[3] = '{0, 1'b1, 40'h80,    {64{8'hFF}}, 64'h0F,        blk_part};
    vecs[4] = '{0, 1'b0, 40'h80,    '0,          '0,            blk_part};
    vecs[5] = '{0, 1'b0, 40'h10080, '0,          '0,            blk_part};
    vecs[6] = '{0, 1'b1, 40'h100,   {64{8'h3C}}, {8{8'h55}},    blk_alt};
    vecs[7] = '{1, 1'b1, 40'h10000, blk_5a,      {64{1'b1}},    blk_5a};
    vecs[8] = '{1, 1'b0, 40'h0,     '0,          '0,            blk_5a};
    vecs[9] = '{1, 1'b1, 40'h0,     {64{8'h11}}, 64'h1,         blk_5a11};

    repeat (3) @(negedge clk);
    check("reset ready", ready4, 512'd1);
    check("reset v",     vo4,    512'd0);
    check("reset data",  data4,  512'd0);
    check("reset0 ready", ready0, 512'd1);
    rst4 = 1'b0; rst0 = 1'b0;

    for (int i = 0; i < 10; i++) txn(vecs[i], i);

    // Response held without yumi; requests offered meanwhile must be ignored
    begin
      int lat;
      @(negedge clk);
      w = 1'b0; addr = 40'h80; v4 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0;
      lat = 0;
      while (!vo4 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("hold latency", 512'(lat), 512'd4);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        w = 1'b1; addr = 40'h80; wdata = '0; mask = '1; v4 = c[0];
        check($sformatf("hold v c%0d", c), vo4, 512'd1);
        check($sformatf("hold data c%0d", c), data4, blk_part);
        check($sformatf("hold ready c%0d", c), ready4, 512'd0);
      end
      @(negedge clk);
      v4 = 1'b0; yumi4 = 1'b1;
      @(posedge clk); #1;
      yumi4 = 1'b0;
      check("hold ready_after_yumi", ready4, 512'd1);
      txn('{0, 1'b0, 40'h80, '0, '0, blk_part}, 20);
    end

    // Asynchronous reset during the wait phase of a write
    @(negedge clk);
    w = 1'b1; addr = 40'h200; wdata = blk_77; mask = '1; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    @(posedge clk); #2;
    check("pre_rst v", vo4, 512'd0);
    rst4 = 1'b1;
    #1;
    check("async_rst ready", ready4, 512'd1);
    check("async_rst v", vo4, 512'd0);
    @(negedge clk);
    rst4 = 1'b0;
    txn('{0, 1'b0, 40'h200, '0, '0, blk_77}, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
